access_control_multi: RTL
=========================

Name: access_control_multi

Overview:
Parametrised successor to the single-user access controller. It compares a digit-serial password against a per-user store of NUM_USERS entries and raises a grant, or a deny pulse. After MAX_FAILS consecutive failures it holds a timed lockout. A granted user can rewrite their own stored password. The block sits between the keypad/debounce front end and the LED/unlock logic.

Parameters:
DIGIT_W, 4, bits per entered digit
PW_DIGITS, 4, digits per password; PW_W = DIGIT_W*PW_DIGITS
NUM_USERS, 4, number of password entries; USER_W = max(1, clog2(NUM_USERS))
MAX_FAILS, 3, consecutive failures that trigger lockout (>=1)
LOCK_CYCLES, 1000, lockout duration in clk cycles (>=1)
DEFAULT_PW, 16'h1234, PW_W-bit reset value of every store entry

Ports:
clk  in  1  system clock, all logic rising-edge
rst  in  1  asynchronous active-low reset
data_in  in  DIGIT_W  digit value, sampled when data_load=1
data_load  in  1  single-cycle digit strobe (already debounced/pulsed upstream)
user_sel  in  USER_W  user index, sampled with the first digit of an entry
change_pw  in  1  single-cycle request to rewrite the password (honoured only in GRANTED)
logout  in  1  single-cycle; ends the session or aborts a partial entry
access_grant  out  1  high while a session is granted
access_deny  out  1  one-cycle pulse on a failed compare
locked  out  1  high during lockout
active_user  out  USER_W  user index of the current or last entry
fail_count  out  clog2(MAX_FAILS+1)  consecutive failures so far

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0; digit counter and fail counter 0; every store entry = DEFAULT_PW.
- States: IDLE, ENTRY, FETCH, COMPARE, DENIED, GRANTED, CHANGE, WRITE, LOCKED.
- IDLE: data_load -> capture user_sel into active_user; shift the digit into the entry register; digit count = 1; go to ENTRY (or FETCH if PW_DIGITS=1).
- ENTRY: each data_load shifts a digit in, first digit ends up most significant. The load that completes PW_DIGITS goes to FETCH.
- FETCH: store read at active_user, 1-cycle read latency. COMPARE: full PW_W equality.
- Latency: last digit load at cycle T -> FETCH T+1 -> COMPARE T+2 -> access_grant=1 (or access_deny=1) from T+3.
- Match: GRANTED; fail_count cleared.
- Mismatch, or active_user >= NUM_USERS: fail_count+1. If the new count reaches MAX_FAILS -> LOCKED; otherwise -> DENIED. DENIED lasts one cycle with access_deny=1, then IDLE.
- LOCKED: locked=1; a LOCK_CYCLES down-counter runs; data_load, change_pw and logout are ignored. On expiry: fail_count=0, go to IDLE. access_deny also pulses on the entry cycle into LOCKED.
- GRANTED: access_grant held. logout -> IDLE. change_pw -> CHANGE; access_grant stays 1.
- CHANGE: collect PW_DIGITS digits as in ENTRY. On completion go to WRITE: one cycle, store[active_user] <= entry register, then return to GRANTED.
- logout during ENTRY or CHANGE: discard the partial entry, clear the digit counter, go to IDLE. No failure is counted and the store is unchanged.
- Simultaneous logout and data_load: logout wins. Simultaneous change_pw and logout in GRANTED: logout wins.
- data_load in FETCH, COMPARE, DENIED or WRITE is dropped.
- fail_count saturates at MAX_FAILS and never wraps.
- The store is not written in any state except WRITE.
- Reset asserted mid-operation: immediate return to reset values, including the store.

Decomposition:
- Package access_control_pkg: state enum, USER_W/PW_W/fail-count width functions, a clog2 helper.
- One sub-module, pw_store: NUM_USERS x PW_W register array, synchronous write, registered 1-cycle read, async active-low reset to DEFAULT_PW.
- FSM, counters and comparator live in the top.

Test Plan:
1. Reset; user_sel=0; load 1,2,3,4 -> access_grant=1 exactly 3 cycles after the 4th load; fail_count=0; then logout -> access_grant=0 the next cycle.
2. User 2 enters 1,2,3,5 -> one-cycle access_deny, fail_count=1, no grant. Then 1,2,3,4 -> grant and fail_count=0.
3. Three wrong entries for user 1 -> access_deny pulse on the 3rd; locked=1 for exactly 1000 cycles; loads during lockout are ignored. Afterwards fail_count=0 and a correct entry grants.
4. Grant user 3; change_pw; enter 9,8,7,6; logout. Then 1,2,3,4 for user 3 -> deny. 9,8,7,6 -> grant. User 0 still accepts 1,2,3,4.
5. Enter 1,2 then logout, then 1,2,3,4 -> grant with fail_count=0. Also drive logout and data_load in the same cycle -> the digit is not captured.
6. user_sel=3 with NUM_USERS=3 override, enter 1,2,3,4 -> deny and fail_count=1. Reset mid-CHANGE -> store back to 16'h1234.

Source files
------------

// File: rtl/access_control_pkg.sv
// Shared state encoding and width helpers for the multi-user access controller.
package access_control_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ENTRY,
    ST_FETCH,
    ST_COMPARE,
    ST_DENIED,
    ST_GRANTED,
    ST_CHANGE,
    ST_WRITE,
    ST_LOCKED
  } state_e;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = 1;
    while (x < v) begin
      x = x * 2;
      r = r + 1;
    end
    return r;
  endfunction

  function automatic int max1(input int v);
    return (v < 1) ? 1 : v;
  endfunction

  function automatic int pw_w(input int digit_w, input int pw_digits);
    return digit_w * pw_digits;
  endfunction

  function automatic int user_w(input int num_users);
    return max1(clog2(num_users));
  endfunction

  function automatic int fail_w(input int max_fails);
    return max1(clog2(max_fails + 1));
  endfunction

  // Down-counter only ever holds LOCK_CYCLES-1 .. 0.
  function automatic int lcnt_w(input int lock_cycles);
    return max1(clog2(lock_cycles));
  endfunction

  function automatic int dcnt_w(input int pw_digits);
    return max1(clog2(pw_digits + 1));
  endfunction

endpackage

// File: rtl/pw_store.sv
// Per-user password register file: synchronous write, registered read
// (data valid the cycle after rd_en), async active-low reset to DEFAULT_PW.
module pw_store
  import access_control_pkg::*;
#(
  parameter int              NUM_USERS  = 4,
  parameter int              PW_W       = 16,
  parameter logic [PW_W-1:0] DEFAULT_PW = 16'h1234,
  localparam int             USER_W     = user_w(NUM_USERS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic [USER_W-1:0] rd_addr,
  output logic [PW_W-1:0]   rd_dat,
  input  logic              wr_en,
  input  logic [USER_W-1:0] wr_addr,
  input  logic [PW_W-1:0]   wr_dat
);

  logic [PW_W-1:0] mem_q [NUM_USERS];
  logic [PW_W-1:0] mem_d [NUM_USERS];
  logic [PW_W-1:0] rd_q;
  logic [PW_W-1:0] rd_d;

  always_comb begin
    mem_d = mem_q;
    rd_d  = rd_q;
    if (wr_en && (int'(wr_addr) < NUM_USERS)) begin
      mem_d[wr_addr] = wr_dat;
    end
    // Addresses past the populated entries read as zero; the caller rejects them anyway.
    if (rd_en) begin
      rd_d = (int'(rd_addr) < NUM_USERS) ? mem_q[rd_addr] : '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_USERS; i++) begin
        mem_q[i] <= DEFAULT_PW;
      end
      rd_q <= '0;
    end else begin
      mem_q <= mem_d;
      rd_q  <= rd_d;
    end
  end

  assign rd_dat = rd_q;

endmodule

// File: rtl/access_control_multi.sv
// Multi-user digit-serial password checker with lockout and self-service password change.
// Last digit at T -> FETCH T+1 -> COMPARE T+2 -> grant/deny visible from T+3.
module access_control_multi
  import access_control_pkg::*;
#(
  parameter int                            DIGIT_W     = 4,
  parameter int                            PW_DIGITS   = 4,
  parameter int                            NUM_USERS   = 4,
  parameter int                            MAX_FAILS   = 3,
  parameter int                            LOCK_CYCLES = 1000,
  parameter logic [DIGIT_W*PW_DIGITS-1:0]  DEFAULT_PW  = 16'h1234,
  localparam int                           PW_W        = pw_w(DIGIT_W, PW_DIGITS),
  localparam int                           USER_W      = user_w(NUM_USERS),
  localparam int                           FAIL_W      = fail_w(MAX_FAILS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DIGIT_W-1:0] data_in,
  input  logic               data_load,
  input  logic [USER_W-1:0]  user_sel,
  input  logic               change_pw,
  input  logic               logout,
  output logic               access_grant,
  output logic               access_deny,
  output logic               locked,
  output logic [USER_W-1:0]  active_user,
  output logic [FAIL_W-1:0]  fail_count
);

  localparam int                DCNT_W     = dcnt_w(PW_DIGITS);
  localparam int                LCNT_W     = lcnt_w(LOCK_CYCLES);
  localparam logic [DCNT_W-1:0] LAST_DIGIT = DCNT_W'(PW_DIGITS - 1);
  localparam logic [FAIL_W-1:0] FAIL_MAX   = FAIL_W'(MAX_FAILS);
  localparam logic [LCNT_W-1:0] LOCK_LOAD  = LCNT_W'(LOCK_CYCLES - 1);

  state_e            state_q, state_d;
  logic [DCNT_W-1:0] dcnt_q, dcnt_d;
  logic [PW_W-1:0]   entry_q, entry_d;
  logic [USER_W-1:0] user_q, user_d;
  logic [FAIL_W-1:0] fail_q, fail_d;
  logic [LCNT_W-1:0] lcnt_q, lcnt_d;
  logic              deny_q, deny_d;

  logic [PW_W-1:0]   store_rd;
  logic [PW_W-1:0]   shifted;
  logic [FAIL_W-1:0] fail_inc;
  logic              pw_match;
  logic              store_re;
  logic              store_we;

  pw_store #(
    .NUM_USERS  (NUM_USERS),
    .PW_W       (PW_W),
    .DEFAULT_PW (DEFAULT_PW)
  ) u_store (
    .clk     (clk),
    .rst     (rst),
    .rd_en   (store_re),
    .rd_addr (user_q),
    .rd_dat  (store_rd),
    .wr_en   (store_we),
    .wr_addr (user_q),
    .wr_dat  (entry_q)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      dcnt_q  <= '0;
      entry_q <= '0;
      user_q  <= '0;
      fail_q  <= '0;
      lcnt_q  <= '0;
      deny_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
      entry_q <= entry_d;
      user_q  <= user_d;
      fail_q  <= fail_d;
      lcnt_q  <= lcnt_d;
      deny_q  <= deny_d;
    end
  end

  // First digit ends up most significant once all digits are shifted in.
  assign shifted  = (entry_q << DIGIT_W) | PW_W'(data_in);
  assign pw_match = (int'(user_q) < NUM_USERS) && (store_rd == entry_q);
  assign fail_inc = (fail_q == FAIL_MAX) ? fail_q : fail_q + 1'b1;

  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    entry_d = entry_q;
    user_d  = user_q;
    fail_d  = fail_q;
    lcnt_d  = lcnt_q;
    deny_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (data_load && !logout) begin
          user_d  = user_sel;
          entry_d = PW_W'(data_in);
          dcnt_d  = DCNT_W'(1);
          state_d = (PW_DIGITS == 1) ? ST_FETCH : ST_ENTRY;
        end
      end
      ST_ENTRY, ST_CHANGE: begin
        if (logout) begin
          dcnt_d  = '0;
          entry_d = '0;
          state_d = ST_IDLE;
        end else if (data_load) begin
          entry_d = shifted;
          if (dcnt_q == LAST_DIGIT) begin
            dcnt_d  = '0;
            state_d = (state_q == ST_ENTRY) ? ST_FETCH : ST_WRITE;
          end else begin
            dcnt_d = dcnt_q + 1'b1;
          end
        end
      end
      ST_FETCH: state_d = ST_COMPARE;
      ST_COMPARE: begin
        dcnt_d = '0;
        if (pw_match) begin
          fail_d  = '0;
          state_d = ST_GRANTED;
        end else begin
          fail_d  = fail_inc;
          deny_d  = 1'b1;
          state_d = (fail_inc == FAIL_MAX) ? ST_LOCKED : ST_DENIED;
          lcnt_d  = LOCK_LOAD;
        end
      end
      ST_DENIED: state_d = ST_IDLE;
      ST_GRANTED: begin
        if (logout) begin
          state_d = ST_IDLE;
        end else if (change_pw) begin
          dcnt_d  = '0;
          entry_d = '0;
          state_d = ST_CHANGE;
        end
      end
      ST_WRITE: state_d = ST_GRANTED;
      ST_LOCKED: begin
        if (lcnt_q == '0) begin
          fail_d  = '0;
          state_d = ST_IDLE;
        end else begin
          lcnt_d = lcnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    access_grant = (state_q == ST_GRANTED) || (state_q == ST_CHANGE) || (state_q == ST_WRITE);
    locked       = (state_q == ST_LOCKED);
    access_deny  = deny_q;
    active_user  = user_q;
    fail_count   = fail_q;
    store_re     = (state_q == ST_FETCH);
    store_we     = (state_q == ST_WRITE);
  end

endmodule
